param_chan_accum: RTL and testbench

Parametrised multi-channel accumulator with typed, width-checked parameters. It is the next-generation typed-parameter test block: it carries an in-band add stream, keeps one running sum per channel, flags overflow per channel, and drains all channels on request. It sits as a leaf under a test top, driven from `clk` with a self-checking bench.

---
 rtl/param_chan_accum_pkg.sv | 16 +
 rtl/param_sat_add.sv | 25 ++
 rtl/param_chan_accum.sv | 153 +++++++++++++++
 tb/tb_param_chan_accum.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_chan_accum_pkg.sv
// Shared types and helpers for the multi-channel accumulator.
package param_chan_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Channel-index width. It never drops below one bit, so CHANNELS=1 still has a port.
  function automatic int chan_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/param_sat_add.sv
// Unsigned adder with a carry-out and an optional clamp to all-ones on overflow.
module param_sat_add #(
  parameter int unsigned WIDTH    = 8,
  parameter logic        SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] w_full;

  // Add at WIDTH+1 bits, then either wrap or clamp the result on carry-out.
  always_comb begin
    w_full = {1'b0, a} + {1'b0, b};
    carry  = w_full[WIDTH];
    if (SATURATE && w_full[WIDTH]) begin
      sum = '1;
    end else begin
      sum = w_full[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/param_chan_accum.sv
// Multi-channel accumulator: one running sum and sticky overflow flag per channel,
// an in-band add stream with one-cycle result beats, and a drain of all channels on request.
module param_chan_accum
  import param_chan_accum_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      CHANNELS = 4,
  parameter logic [WIDTH-1:0] INIT     = '0,
  parameter logic             SATURATE = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [chan_w(CHANNELS)-1:0]   in_chan,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          flush_req,
  output logic                          out_valid,
  output logic [chan_w(CHANNELS)-1:0]   out_chan,
  output logic [WIDTH-1:0]              out_sum,
  output logic                          out_ovf,
  output logic                          out_err,
  output logic                          flush_done
);

  localparam int unsigned CW = chan_w(CHANNELS);

  state_e               r_state;
  logic [CW-1:0]        r_idx;
  logic [WIDTH-1:0]     r_acc [CHANNELS];
  logic [CHANNELS-1:0]  r_ovf;

  logic                 r_out_valid;
  logic [CW-1:0]        r_out_chan;
  logic [WIDTH-1:0]     r_out_sum;
  logic                 r_out_ovf;
  logic                 r_out_err;
  logic                 r_flush_done;

  logic                 w_in_range;
  logic [WIDTH-1:0]     w_acc_rd;
  logic                 w_ovf_rd;
  logic [WIDTH-1:0]     w_fl_acc;
  logic                 w_fl_ovf;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_carry;

  // Single adder shared by every channel; the operand is muxed from the addressed entry.
  param_sat_add #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_add (
    .a     (w_acc_rd),
    .b     (in_data),
    .sum   (w_sum),
    .carry (w_carry)
  );

  // Decode the requested channel (range check + read) and fetch the entry under the flush index.
  always_comb begin
    w_in_range = 1'b0;
    w_acc_rd   = INIT;
    w_ovf_rd   = 1'b0;
    w_fl_acc   = INIT;
    w_fl_ovf   = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (in_chan == CW'(i)) begin
        w_in_range = 1'b1;
        w_acc_rd   = r_acc[i];
        w_ovf_rd   = r_ovf[i];
      end
      if (r_idx == CW'(i)) begin
        w_fl_acc = r_acc[i];
        w_fl_ovf = r_ovf[i];
      end
    end
  end

  // Control FSM, accumulator storage and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ACCUM;
      r_idx        <= '0;
      r_ovf        <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_acc[i] <= INIT;
      end
      r_out_valid  <= 1'b0;
      r_out_chan   <= '0;
      r_out_sum    <= '0;
      r_out_ovf    <= 1'b0;
      r_out_err    <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_out_err    <= 1'b0;
      r_flush_done <= 1'b0;
      case (r_state)
        ACCUM: begin
          if (in_valid) begin
            if (w_in_range) begin
              for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (in_chan == CW'(i)) begin
                  r_acc[i] <= w_sum;
                  r_ovf[i] <= r_ovf[i] | w_carry;
                end
              end
              r_out_valid <= 1'b1;
              r_out_chan  <= in_chan;
              r_out_sum   <= w_sum;
              r_out_ovf   <= w_ovf_rd | w_carry;
            end else begin
              r_out_err <= 1'b1;
            end
          end
          // A same-cycle add lands first, so the drain of that channel sees the new value.
          if (flush_req) begin
            r_state <= FLUSH;
            r_idx   <= '0;
          end
        end
        FLUSH: begin
          r_out_valid <= 1'b1;
          r_out_chan  <= r_idx;
          r_out_sum   <= w_fl_acc;
          r_out_ovf   <= w_fl_ovf;
          for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (r_idx == CW'(i)) begin
              r_acc[i] <= INIT;
              r_ovf[i] <= 1'b0;
            end
          end
          if (r_idx == CW'(CHANNELS - 1)) begin
            r_flush_done <= 1'b1;
            r_state      <= ACCUM;
            r_idx        <= '0;
          end else begin
            r_idx <= r_idx + CW'(1);
          end
        end
      endcase
    end
  end

  assign in_ready   = (r_state == ACCUM);
  assign out_valid  = r_out_valid;
  assign out_chan   = r_out_chan;
  assign out_sum    = r_out_sum;
  assign out_ovf    = r_out_ovf;
  assign out_err    = r_out_err;
  assign flush_done = r_flush_done;

endmodule

// File: tb/tb_param_chan_accum.sv
// Bench for param_chan_accum: four configurations share one stimulus stream; each scenario
// watches one of them against a reference model and a queue of expected result beats.
module tb_param_chan_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       flush_req;
  logic [1:0] in_chan;
  logic [7:0] in_data;

  logic       rdy [4];
  logic       ov  [4];
  logic       oo  [4];
  logic       oe  [4];
  logic       od  [4];
  logic [1:0] oc  [4];
  logic [7:0] os  [4];

  always #5 clk = ~clk;

  // 0: defaults, 1: SATURATE=1, 2: INIT=8'h10, 3: CHANNELS=3
  param_chan_accum #(.WIDTH(8), .CHANNELS(4)) u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_chan(in_chan),
    .in_data(in_data), .flush_req(flush_req), .out_valid(ov[0]), .out_chan(oc[0]),
    .out_sum(os[0]), .out_ovf(oo[0]), .out_err(oe[0]), .flush_done(od[0]));
  param_chan_accum #(.WIDTH(8), .CHANNELS(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_chan(in_chan),
    .in_data(in_data), .flush_req(flush_req), .out_valid(ov[1]), .out_chan(oc[1]),
    .out_sum(os[1]), .out_ovf(oo[1]), .out_err(oe[1]), .flush_done(od[1]));
  param_chan_accum #(.WIDTH(8), .CHANNELS(4), .INIT(8'h10)) u_init (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .in_chan(in_chan),
    .in_data(in_data), .flush_req(flush_req), .out_valid(ov[2]), .out_chan(oc[2]),
    .out_sum(os[2]), .out_ovf(oo[2]), .out_err(oe[2]), .flush_done(od[2]));
  param_chan_accum #(.WIDTH(8), .CHANNELS(3)) u_c3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]), .in_chan(in_chan),
    .in_data(in_data), .flush_req(flush_req), .out_valid(ov[3]), .out_chan(oc[3]),
    .out_sum(os[3]), .out_ovf(oo[3]), .out_err(oe[3]), .flush_done(od[3]));

  typedef struct {
    logic [1:0] chan;
    logic [7:0] sum;
    logic       ovf;
    logic       done;
    int         due;
  } beat_t;

  beat_t      sb [$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  logic [7:0] m_acc [4];
  logic       m_ovf [4];
  int         m_chans;
  logic [7:0] m_init;
  logic       m_sat;
  int         m_busy;
  logic       m_err_now;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_cfg(input int s);
    m_chans   = (s == 3) ? 3 : 4;
    m_init    = (s == 2) ? 8'h10 : 8'h00;
    m_sat     = (s == 1);
    m_busy    = 0;
    m_err_now = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = m_init;
      m_ovf[i] = 1'b0;
    end
    sb.delete();
  endtask

  // Row layout: {valid, chan[1:0], data[7:0], flush}. Drives the DUTs and advances the model.
  task automatic drive(input logic [11:0] row);
    logic [8:0] t;
    logic [1:0] ch;
    beat_t      b;
    in_valid  = row[11];
    in_chan   = row[10:9];
    in_data   = row[8:1];
    flush_req = row[0];
    ch        = row[10:9];
    m_err_now = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
      return;
    end
    if (row[11]) begin
      if (int'(ch) >= m_chans) begin
        m_err_now = 1'b1;
      end else begin
        t = {1'b0, m_acc[ch]} + {1'b0, row[8:1]};
        if (t[8]) begin
          m_ovf[ch] = 1'b1;
          m_acc[ch] = m_sat ? 8'hFF : t[7:0];
        end else begin
          m_acc[ch] = t[7:0];
        end
        b.chan = ch; b.sum = m_acc[ch]; b.ovf = m_ovf[ch]; b.done = 1'b0; b.due = cyc + 1;
        sb.push_back(b);
      end
    end
    if (row[0]) begin
      for (int i = 0; i < m_chans; i++) begin
        b.chan = 2'(i); b.sum = m_acc[i]; b.ovf = m_ovf[i];
        b.done = (i == m_chans - 1); b.due = cyc + 2 + i;
        sb.push_back(b);
        m_acc[i] = m_init;
        m_ovf[i] = 1'b0;
      end
      m_busy = m_chans;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_chan = '0; in_data = '0; flush_req = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_chan = '0; in_data = '0; flush_req = 1'b0;
    tick();
    for (int s = 0; s < 4; s++) begin
      checks++;
      if ({ov[s], oc[s], os[s], oo[s], oe[s], od[s], rdy[s]} !== 15'b1) begin
        errors++;
        $display("FAIL reset_state dut %0d: got v%b ch%0d sum %h ovf %b err %b done %b rdy %b, want all 0 rdy 1",
                 s, ov[s], oc[s], os[s], oo[s], oe[s], od[s], rdy[s]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_cfg(0);
    for (int k = 0; k < 5; k++) begin
      drive(12'h000);
      tick();
      checks++;
      if ({ov[0], oc[0], os[0], oo[0], oe[0], od[0], rdy[0]} !== 15'b1) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got v%b ch%0d sum %h ovf %b err %b done %b rdy %b, want all 0 rdy 1",
                 cyc, ov[0], oc[0], os[0], oo[0], oe[0], od[0], rdy[0]);
      end
    end
  endtask

  // Back-to-back adds to one channel, then to others; s=0 wraps, s=1 saturates.
  task automatic test_add_chain(input int s);
    logic [11:0] tab [8];
    beat_t       e;
    tab = '{{1'b1, 2'd1, 8'd200, 1'b0}, {1'b1, 2'd1, 8'd100, 1'b0}, {1'b1, 2'd1, 8'd1, 1'b0},
            {1'b1, 2'd0, 8'd7, 1'b0},   {1'b1, 2'd3, 8'd255, 1'b0}, {1'b1, 2'd3, 8'd1, 1'b0},
            12'h000, 12'h000};
    model_cfg(s);
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(tab[k]);
      tick();
      checks++;
      if (rdy[s] !== (m_busy == 0) || oe[s] !== m_err_now) begin
        errors++;
        $display("FAIL add_ctl dut %0d cyc %0d: ready %b err %b, want ready %b err %b",
                 s, cyc, rdy[s], oe[s], m_busy == 0, m_err_now);
      end
      if (ov[s] === 1'b1 || od[s] === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL add_beat dut %0d cyc %0d: unexpected beat ch%0d sum %h", s, cyc, oc[s], os[s]);
        end else begin
          e = sb.pop_front();
          if (ov[s] !== 1'b1 || oc[s] !== e.chan || os[s] !== e.sum || oo[s] !== e.ovf ||
              od[s] !== e.done || cyc != e.due) begin
            errors++;
            $display("FAIL add_beat dut %0d cyc %0d: got v%b ch%0d sum %h ovf %b done %b, want ch%0d sum %h ovf %b done %b at cyc %0d",
                     s, cyc, ov[s], oc[s], os[s], oo[s], od[s], e.chan, e.sum, e.ovf, e.done, e.due);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL add_missing dut %0d: %0d beats never seen, want 0", s, sb.size());
    end
  endtask

  // INIT=8'h10: add accepted alongside flush_req, flush_req held during the drain, then reuse.
  task automatic test_flush();
    logic [11:0] tab [10];
    beat_t       e;
    tab = '{{1'b1, 2'd0, 8'd5, 1'b0}, {1'b1, 2'd2, 8'd7, 1'b1}, {1'b0, 2'd0, 8'd0, 1'b1},
            {1'b0, 2'd0, 8'd0, 1'b1}, {1'b0, 2'd0, 8'd0, 1'b1}, 12'h000, 12'h000,
            {1'b1, 2'd0, 8'd1, 1'b0}, 12'h000, 12'h000};
    model_cfg(2);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(tab[k]);
      tick();
      checks++;
      if (rdy[2] !== (m_busy == 0) || oe[2] !== m_err_now) begin
        errors++;
        $display("FAIL flush_ctl cyc %0d: ready %b err %b, want ready %b err %b",
                 cyc, rdy[2], oe[2], m_busy == 0, m_err_now);
      end
      if (ov[2] === 1'b1 || od[2] === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL flush_beat cyc %0d: unexpected beat ch%0d sum %h", cyc, oc[2], os[2]);
        end else begin
          e = sb.pop_front();
          if (ov[2] !== 1'b1 || oc[2] !== e.chan || os[2] !== e.sum || oo[2] !== e.ovf ||
              od[2] !== e.done || cyc != e.due) begin
            errors++;
            $display("FAIL flush_beat cyc %0d: got v%b ch%0d sum %h ovf %b done %b, want ch%0d sum %h ovf %b done %b at cyc %0d",
                     cyc, ov[2], oc[2], os[2], oo[2], od[2], e.chan, e.sum, e.ovf, e.done, e.due);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL flush_missing: %0d beats never seen, want 0", sb.size());
    end
  endtask

  // CHANNELS=3: channel 3 is dropped with an error pulse, and a drain is three beats of zero.
  task automatic test_out_of_range();
    logic [11:0] tab [8];
    beat_t       e;
    tab = '{{1'b1, 2'd3, 8'd9, 1'b0}, 12'h000, {1'b0, 2'd0, 8'd0, 1'b1}, 12'h000,
            12'h000, 12'h000, 12'h000, 12'h000};
    model_cfg(3);
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(tab[k]);
      tick();
      checks++;
      if (rdy[3] !== (m_busy == 0) || oe[3] !== m_err_now) begin
        errors++;
        $display("FAIL range_ctl cyc %0d: ready %b err %b, want ready %b err %b",
                 cyc, rdy[3], oe[3], m_busy == 0, m_err_now);
      end
      if (ov[3] === 1'b1 || od[3] === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL range_beat cyc %0d: unexpected beat ch%0d sum %h", cyc, oc[3], os[3]);
        end else begin
          e = sb.pop_front();
          if (ov[3] !== 1'b1 || oc[3] !== e.chan || os[3] !== e.sum || oo[3] !== e.ovf ||
              od[3] !== e.done || cyc != e.due) begin
            errors++;
            $display("FAIL range_beat cyc %0d: got v%b ch%0d sum %h ovf %b done %b, want ch%0d sum %h ovf %b done %b at cyc %0d",
                     cyc, ov[3], oc[3], os[3], oo[3], od[3], e.chan, e.sum, e.ovf, e.done, e.due);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL range_missing: %0d beats never seen, want 0", sb.size());
    end
  endtask

  // Reset lands after the second drain beat; fresh adds must start from INIT, not stale sums.
  task automatic test_reset_mid_flush();
    logic [11:0] tab [9];
    beat_t       e;
    tab = '{{1'b1, 2'd0, 8'd50, 1'b0}, {1'b1, 2'd2, 8'd60, 1'b0}, {1'b0, 2'd0, 8'd0, 1'b1},
            12'h000, 12'h000, {1'b1, 2'd0, 8'd3, 1'b0}, {1'b1, 2'd2, 8'd4, 1'b0},
            12'h000, 12'h000};
    model_cfg(0);
    do_reset();
    for (int k = 0; k < 9; k++) begin
      if (k == 5) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ov[0], oc[0], os[0], oo[0], oe[0], od[0], rdy[0]} !== 15'b1) begin
          errors++;
          $display("FAIL midrst_state cyc %0d: got v%b ch%0d sum %h ovf %b err %b done %b rdy %b, want all 0 rdy 1",
                   cyc, ov[0], oc[0], os[0], oo[0], oe[0], od[0], rdy[0]);
        end
        model_cfg(0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
      end
      drive(tab[k]);
      tick();
      checks++;
      if (rdy[0] !== (m_busy == 0) || oe[0] !== m_err_now) begin
        errors++;
        $display("FAIL midrst_ctl cyc %0d: ready %b err %b, want ready %b err %b",
                 cyc, rdy[0], oe[0], m_busy == 0, m_err_now);
      end
      if (ov[0] === 1'b1 || od[0] === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL midrst_beat cyc %0d: unexpected beat ch%0d sum %h", cyc, oc[0], os[0]);
        end else begin
          e = sb.pop_front();
          if (ov[0] !== 1'b1 || oc[0] !== e.chan || os[0] !== e.sum || oo[0] !== e.ovf ||
              od[0] !== e.done || cyc != e.due) begin
            errors++;
            $display("FAIL midrst_beat cyc %0d: got v%b ch%0d sum %h ovf %b done %b, want ch%0d sum %h ovf %b done %b at cyc %0d",
                     cyc, ov[0], oc[0], os[0], oo[0], od[0], e.chan, e.sum, e.ovf, e.done, e.due);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL midrst_missing: %0d beats never seen, want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_chain(0);
    test_add_chain(1);
    test_flush();
    test_out_of_range();
    test_reset_mid_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
